// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sha256_pkg
// Purpose : Shared SHA-256 sizing, controller state type and FIPS 180-4
//           constants (IV, K) so the round controller and the datapath agree.
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
package sha256_pkg;

  localparam int ROUNDS  = 64;  // compression rounds per block
  localparam int CNT_W   = 6;   // round index width, 2**CNT_W == ROUNDS
  localparam int SCHED_T = 16;  // first round fed from the computed schedule

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ROUND = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage
`default_nettype wire

// File: rtl/sha256_round_counter.sv
`default_nettype none
// ============================================================================
// Module  : sha256_round_counter
// Purpose : Round index counter with synchronous clear, enable and a
//           last-round flag. Wraps to zero after the last round.
// Ports   : CLK, RST (async, active-high)
//           clr_i  - force count to zero (has priority over en_i)
//           en_i   - advance one round
//           cnt_o  - current round index
//           last_o - cnt_o equals ROUNDS-1
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
module sha256_round_counter #(
  parameter int CNT_W  = 6,
  parameter int ROUNDS = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last_o = (cnt_q == CNT_W'(ROUNDS - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sha256_round_ctrl
// Purpose : Sequencer for one SHA-256 compression per accepted 512-bit block.
//           Generates IV load, working-register load, per-round enable,
//           round index (K-ROM address), schedule select, hash update and a
//           done pulse. Holds no data.
// Ports   : CLK, RST (async, active-high)
//           blk_valid_i / blk_first_i / blk_ready_o / msg_ld_o - block handshake
//           init_iv_o, ld_work_o, round_en_o, hash_upd_o, done_o - strobes
//           round_idx_o - round t, w_sched_o - use W[t] (1) or M[t] (0)
//           busy_o - not idle
//           abort_i - cancel current block (SHA256_CTRL_ABORT_EN builds only)
// Options : SHA256_CTRL_ABORT_EN - adds abort_i and the abort path
// Revision: 1.0 - initial release
// ============================================================================
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS  = sha256_pkg::ROUNDS,
  parameter int CNT_W   = sha256_pkg::CNT_W,
  parameter int SCHED_T = sha256_pkg::SCHED_T
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             blk_valid_i,
  input  logic             blk_first_i,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             blk_ready_o,
  output logic             msg_ld_o,
  output logic             init_iv_o,
  output logic             ld_work_o,
  output logic             round_en_o,
  output logic [CNT_W-1:0] round_idx_o,
  output logic             w_sched_o,
  output logic             hash_upd_o,
  output logic             done_o,
  output logic             busy_o
);

  state_t state_q;

  logic init_iv_q;
  logic ld_work_q;
  logic round_en_q;
  logic w_sched_q;
  logic hash_upd_q;
  logic done_q;

  logic cnt_last;
  logic abort_act;

`ifdef SHA256_CTRL_ABORT_EN
  // Abort is only meaningful while a block is in flight; in IDLE it must not
  // interfere with an accept happening in the same cycle.
  assign abort_act = abort_i & (state_q != ST_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign blk_ready_o = (state_q == ST_IDLE);
  assign busy_o      = ~blk_ready_o;
  assign msg_ld_o    = blk_valid_i & blk_ready_o;

  assign init_iv_o   = init_iv_q;
  assign ld_work_o   = ld_work_q;
  assign round_en_o  = round_en_q;
  assign w_sched_o   = w_sched_q;
  assign hash_upd_o  = hash_upd_q;
  assign done_o      = done_q;

  // Round index doubles as the K-ROM address; it stays 0 outside ROUND
  // because the counter is cleared in LOAD and wraps after the last round.
  sha256_round_counter #(
    .CNT_W  (CNT_W),
    .ROUNDS (ROUNDS)
  ) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr_i  ((state_q == ST_LOAD) | abort_act),
    .en_i   (state_q == ST_ROUND),
    .cnt_o  (round_idx_o),
    .last_o (cnt_last)
  );

  // Outputs are registered together with the state, so each strobe is the
  // decode of the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      init_iv_q  <= 1'b0;
      ld_work_q  <= 1'b0;
      round_en_q <= 1'b0;
      w_sched_q  <= 1'b0;
      hash_upd_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      init_iv_q  <= 1'b0;
      ld_work_q  <= 1'b0;
      round_en_q <= 1'b0;
      w_sched_q  <= 1'b0;
      hash_upd_q <= 1'b0;
      done_q     <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (msg_ld_o) begin
            if (blk_first_i) begin
              state_q   <= ST_INIT;
              init_iv_q <= 1'b1;
            end else begin
              state_q   <= ST_LOAD;
              ld_work_q <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          state_q   <= ST_LOAD;
          ld_work_q <= 1'b1;
        end
        ST_LOAD: begin
          state_q    <= ST_ROUND;
          round_en_q <= 1'b1;
        end
        ST_ROUND: begin
          if (cnt_last) begin
            state_q    <= ST_FINAL;
            hash_upd_q <= 1'b1;
          end else begin
            round_en_q <= 1'b1;
            // Next round index is cnt+1, so compare against SCHED_T-1.
            w_sched_q  <= (round_idx_o >= CNT_W'(SCHED_T - 1));
          end
        end
        ST_FINAL: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (abort_act) begin
        state_q    <= ST_IDLE;
        init_iv_q  <= 1'b0;
        ld_work_q  <= 1'b0;
        round_en_q <= 1'b0;
        w_sched_q  <= 1'b0;
        hash_upd_q <= 1'b0;
        done_q     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha256_round_ctrl
// Purpose : Self-checking bench for sha256_round_ctrl. A cycle-offset model
//           predicts every output each cycle; a behavioural SHA-256 datapath
//           driven by the controller strobes yields digests that are compared
//           against NIST vectors and a software compression function.
// Ports   : none
// Options : SHA256_CTRL_ABORT_EN - connects abort_i and runs the abort case
// Revision: 1.0 - initial release
// ============================================================================
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             blk_valid_i = 1'b0;
  logic             blk_first_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             blk_ready_o, msg_ld_o, init_iv_o, ld_work_o, round_en_o;
  logic [CNT_W-1:0] round_idx_o;
  logic             w_sched_o, hash_upd_o, done_o, busy_o;

  always #5 CLK = ~CLK;

  sha256_round_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .blk_valid_i (blk_valid_i),
    .blk_first_i (blk_first_i),
`ifdef SHA256_CTRL_ABORT_EN
    .abort_i     (abort_i),
`endif
    .blk_ready_o (blk_ready_o),
    .msg_ld_o    (msg_ld_o),
    .init_iv_o   (init_iv_o),
    .ld_work_o   (ld_work_o),
    .round_en_o  (round_en_o),
    .round_idx_o (round_idx_o),
    .w_sched_o   (w_sched_o),
    .hash_upd_o  (hash_upd_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- SHA-256 helpers ----------------
  localparam logic [255:0] IV_P = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] N56_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] N56_B2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] N56_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sched_fn(input logic [31:0] w2, w7, w15, w16);
    logic [31:0] s0, s1;
    s0 = rotr(w15, 7) ^ rotr(w15, 18) ^ (w15 >> 3);
    s1 = rotr(w2, 17) ^ rotr(w2, 19) ^ (w2 >> 10);
    return s1 + w7 + s0 + w16;
  endfunction

  function automatic logic [255:0] round_fn(input logic [255:0] v, input logic [31:0] wt, input logic [31:0] kt);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kt + wt;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [0:63];
    logic [255:0] v;
    v = hin;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[511 - 32*t -: 32];
      else        w[t] = sched_fn(w[t-2], w[t-7], w[t-15], w[t-16]);
      v = round_fn(v, w[t], K[t]);
    end
    return add8(hin, v);
  endfunction

  // ---------------- behavioural datapath driven by the strobes ----------------
  logic [511:0] msg_buf = '0;
  logic [255:0] Hm = '0;
  logic [255:0] wkm = '0;
  logic [31:0]  Wm [0:ROUNDS-1];

  function automatic logic [31:0] wt_fn(input int t, input bit sched);
    if (!sched) return (t < 16) ? msg_buf[511 - 32*t -: 32] : 32'hdeadbeef;
    if (t < 16) return 32'hbadc0de0;
    return sched_fn(Wm[t-2], Wm[t-7], Wm[t-15], Wm[t-16]);
  endfunction

  always @(posedge CLK) begin
    if (init_iv_o) Hm <= IV_P;
    if (ld_work_o) wkm <= Hm;
    if (round_en_o) begin
      Wm[int'(round_idx_o)] <= wt_fn(int'(round_idx_o), w_sched_o);
      wkm <= round_fn(wkm, wt_fn(int'(round_idx_o), w_sched_o), K[int'(round_idx_o)]);
    end
    if (hash_upd_o) Hm <= add8(Hm, wkm);
  end

  // ---------------- cycle reference model ----------------
  // Expected outputs are a function of cycles elapsed since accept.
  bit m_act = 1'b0;
  bit m_first = 1'b0;
  int m_ofs = 0;

  initial begin
    logic [14:0] got, exp;
    int b, o, ri;
    bit e_init, e_ld, e_rnd, e_sch, e_hash, e_done, e_mld;
    forever begin
      @(negedge CLK);
      if (RST) m_act = 1'b0;
      b = m_first ? 1 : 0;
      o = m_ofs;
      e_init = m_act && m_first && (o == 1);
      e_ld   = m_act && (o == 1 + b);
      e_rnd  = m_act && (o >= 2 + b) && (o <= 1 + b + ROUNDS);
      ri     = e_rnd ? (o - 2 - b) : 0;
      e_sch  = e_rnd && (ri >= SCHED_T);
      e_hash = m_act && (o == 2 + b + ROUNDS);
      e_done = m_act && (o == 3 + b + ROUNDS);
      e_mld  = blk_valid_i && !m_act;
      exp = {!m_act, e_mld, e_init, e_ld, e_rnd, e_sch, e_hash, e_done, m_act, CNT_W'(ri)};
      got = {blk_ready_o, msg_ld_o, init_iv_o, ld_work_o, round_en_o, w_sched_o,
             hash_upd_o, done_o, busy_o, round_idx_o};
      check_eq("cycle_outputs", 256'(got), 256'(exp));
      if (RST) begin
        m_act = 1'b0;
      end else if (m_act && abort_i) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_ofs++;
        if (m_ofs > 3 + b + ROUNDS) m_act = 1'b0;
      end else if (e_mld) begin
        m_act = 1'b1;
        m_ofs = 1;
        m_first = blk_first_i;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_block(input bit first, input logic [511:0] blk);
    bit ok = 1'b0;
    @(posedge CLK); #1;
    msg_buf = blk;
    blk_first_i = first;
    blk_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (msg_ld_o) begin ok = 1'b1; break; end
    end
    check_eq("accept_seen", 256'(ok), 256'(1));
    @(posedge CLK); #1;
    blk_valid_i = 1'b0;
  endtask

  // Optionally toggles blk_valid_i/blk_first_i while busy; returns at done_o.
  task automatic wait_done(input bit toggle);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (done_o) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
      if (toggle) begin
        blk_valid_i = 1'($urandom_range(0, 1));
        blk_first_i = 1'($urandom_range(0, 1));
      end
    end
    blk_valid_i = 1'b0;
    check_eq("done_seen", 256'(ok), 256'(1));
  endtask

  task automatic wait_idx(input int idx);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (round_en_o && int'(round_idx_o) == idx) begin ok = 1'b1; break; end
    end
    check_eq("idx_seen", 256'(ok), 256'(1));
  endtask

  initial begin
    logic [255:0] exp_h;
    logic [511:0] rblk;
    bit first;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);

    // First block "abc"
    send_block(1'b1, ABC_BLK);
    wait_done(1'b0);
    check_eq("abc_digest", Hm, ABC_DIG);

    // Two-block message, second block offered right after done_o
    send_block(1'b1, N56_B1);
    wait_done(1'b0);
    send_block(1'b0, N56_B2);
    wait_done(1'b0);
    check_eq("n56_digest", Hm, N56_DIG);

    // Valid held high across several blocks
    @(posedge CLK); #1;
    msg_buf = ABC_BLK;
    blk_first_i = 1'b1;
    blk_valid_i = 1'b1;
    repeat (180) @(posedge CLK);
    #1 blk_valid_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!busy_o) break;
    end
    check_eq("held_valid_digest", Hm, ABC_DIG);

    // Randomized blocks, random gaps and valid noise while busy
    exp_h = ABC_DIG;
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 4)) @(posedge CLK);
      first = 1'($urandom_range(0, 1));
      for (int w = 0; w < 16; w++) rblk[32*w +: 32] = $urandom;
      exp_h = sha_compress(first ? IV_P : exp_h, rblk);
      send_block(first, rblk);
      wait_done(1'b1);
      check_eq("rand_digest", Hm, exp_h);
    end

    // Reset in the middle of ROUND
    send_block(1'b1, ABC_BLK);
    wait_idx(30);
    #2 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_busy", 256'(busy_o), 256'(0));
    check_eq("rst_ready", 256'(blk_ready_o), 256'(1));
    repeat (80) @(posedge CLK);
    check_eq("rst_h_unchanged", Hm, IV_P);

`ifdef SHA256_CTRL_ABORT_EN
    // Abort a continuation block at round 10; H must not move
    send_block(1'b0, N56_B1);
    wait_idx(9);
    @(posedge CLK); #1 abort_i = 1'b1;
    @(posedge CLK); #1 abort_i = 1'b0;
    @(negedge CLK);
    check_eq("abort_idle", 256'(busy_o), 256'(0));
    repeat (80) @(posedge CLK);
    check_eq("abort_h_unchanged", Hm, IV_P);
    // Abort while idle, coincident with an accept: block still runs
    @(posedge CLK); #1 abort_i = 1'b1;
    send_block(1'b1, ABC_BLK);
    abort_i = 1'b0;
    wait_done(1'b0);
    check_eq("abort_idle_digest", Hm, ABC_DIG);
`endif

    repeat (4) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
